muldiv_unit: RTL and testbench

- Parametrised multi-cycle M-extension execute unit. It sits beside the single-cycle ALU in the execute stage.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a shared iterative radix-2 shift/add–subtract datapath.
- Uses a start/done handshake so the pipeline control can stall the pipeline while the unit is busy.
- Results follow the RISC-V M-extension rules, including divide-by-zero and signed overflow.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension (start/done handshake).
// Define MULDIV_FASTPATH_EN to finish divide-by-zero, signed overflow and multiply-by-zero in two cycles.
module muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state;
    logic [2:0]           op_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic                 div0_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [WIDTH-1:0]     opnd_q;   // multiplicand or divisor magnitude
    logic [PW-1:0]        prod_q;   // {hi, lo}: product, or {remainder, quotient}

    // Operand decode and magnitudes
    logic             is_div_c;
    logic             signed_a_c;
    logic             signed_b_c;
    logic             sa_c;
    logic             sb_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;

    assign is_div_c   = op[2];
    assign signed_a_c = is_div_c ? ~op[0] : (op[1:0] != 2'b11);
    assign signed_b_c = is_div_c ? ~op[0] : ~op[1];
    assign sa_c       = signed_a_c & a[WIDTH-1];
    assign sb_c       = signed_b_c & b[WIDTH-1];
    assign mag_a_c    = sa_c ? WIDTH'(-a) : a;
    assign mag_b_c    = sb_c ? WIDTH'(-b) : b;

    // One shift/add multiply step
    logic [WIDTH:0]  mul_sum_c;
    logic [PW-1:0]   mul_next_c;

    assign mul_sum_c  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next_c = {mul_sum_c, prod_q[WIDTH-1:1]};

    // One restoring-division step
    logic [WIDTH:0]   rem_sh_c;
    logic             no_borrow_c;
    logic [WIDTH-1:0] rem_new_c;
    logic [PW-1:0]    div_next_c;

    assign rem_sh_c    = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
    assign no_borrow_c = rem_sh_c >= {1'b0, opnd_q};
    assign rem_new_c   = no_borrow_c ? WIDTH'(rem_sh_c - {1'b0, opnd_q}) : WIDTH'(rem_sh_c);
    assign div_next_c  = {rem_new_c, prod_q[WIDTH-2:0], no_borrow_c};

    // Sign correction and output selection
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;
    logic [WIDTH-1:0] fix_res_c;

    always_comb begin
        prod_fix_c = (sign_a_q ^ sign_b_q) ? PW'(-prod_q) : prod_q;
        quo_fix_c  = (sign_a_q ^ sign_b_q) ? WIDTH'(-prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
        rem_fix_c  = sign_a_q ? WIDTH'(-prod_q[PW-1:WIDTH]) : prod_q[PW-1:WIDTH];
        fix_res_c  = prod_fix_c[PW-1:WIDTH];
        if (div0_q) begin
            quo_fix_c = {WIDTH{1'b1}};
        end
        unique case (op_q)
            3'b000:         fix_res_c = prod_fix_c[WIDTH-1:0];
            3'b100, 3'b101: fix_res_c = quo_fix_c;
            3'b110, 3'b111: fix_res_c = rem_fix_c;
            default:        fix_res_c = prod_fix_c[PW-1:WIDTH];
        endcase
    end

`ifdef MULDIV_FASTPATH_EN
    // Results that need no iteration
    logic             div0_c;
    logic             ovf_c;
    logic             mzero_c;
    logic             fast_c;
    logic [WIDTH-1:0] fast_res_c;

    assign div0_c  = is_div_c & (b == '0);
    assign ovf_c   = is_div_c & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
    assign mzero_c = ~is_div_c & ((a == '0) | (b == '0));
    assign fast_c  = div0_c | ovf_c | mzero_c;

    always_comb begin
        fast_res_c = '0;
        if (div0_c) begin
            fast_res_c = op[1] ? a : {WIDTH{1'b1}};
        end else if (ovf_c) begin
            fast_res_c = op[1] ? '0 : a;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            count_q  <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q     <= op;
                            sign_a_q <= sa_c;
                            sign_b_q <= sb_c;
                            div0_q   <= is_div_c & (b == '0);
                            count_q  <= '0;
                            busy     <= 1'b1;
                            opnd_q   <= is_div_c ? mag_b_c : mag_a_c;
`ifdef MULDIV_FASTPATH_EN
                            if (fast_c) begin
                                prod_q <= {{WIDTH{1'b0}}, fast_res_c};
                                state  <= S_DONE;
                            end else begin
                                prod_q <= {{WIDTH{1'b0}}, is_div_c ? mag_a_c : mag_b_c};
                                state  <= S_CALC;
                            end
`else
                            prod_q   <= {{WIDTH{1'b0}}, is_div_c ? mag_a_c : mag_b_c};
                            state    <= S_CALC;
`endif
                        end
                    end
                    S_CALC: begin
                        prod_q  <= op_q[2] ? div_next_c : mul_next_c;
                        count_q <= count_q + CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result <= fix_res_c;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    S_DONE: begin
                        result <= prod_q[WIDTH-1:0];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed M-extension cases plus random operations
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension result computed with 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        ix = $signed(x);
        iy = $signed(y);
        p  = '0;
        case (o)
            3'b000: begin p = sx * sy; return p[31:0];  end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * uy; return p[63:32]; end
            3'b011: begin p = ux * uy; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return x;
                return 32'(ix / iy);
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2]) return (y == 0) || (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF);
        return (x == 0) || (y == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN_INT;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation starting in the current (low) phase; returns in the done cycle's low phase.
    // poke > 0 pulses a stray start at that cycle while the unit is busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [31:0] exp_r;
        int          exp_lat;
        int          cyc;
        bit          busy_ok;
        exp_r   = model(o, x, y);
        exp_lat = 34;
`ifdef MULDIV_FASTPATH_EN
        if (is_fast(o, x, y)) exp_lat = 2;
`else
        if (is_fast(o, x, y)) exp_lat = 34;
`endif
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        cyc = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
            if (!done && poke > 0 && cyc == poke) begin
                start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 200);
        start = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("result", result, exp_r);
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("busy_in_done_cycle", 32'(busy), 32'd0);
    endtask

    task automatic watch_idle(input int cycles, input logic [31:0] exp_res, input string tag);
        bit seen_done;
        bit seen_busy;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check({tag, "_no_done"}, 32'(seen_done), 32'd0);
        check({tag, "_no_busy"}, 32'(seen_busy), 32'd0);
        check({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        rstn = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        #3 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed multiplies
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5);
        run_op(3'b001, MIN_INT, MIN_INT, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'h0, 32'h1234_5678, 0);
        // Directed divides
        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'b101, 32'd100, 32'd7, 0);
        run_op(3'b111, 32'd100, 32'd7, 0);
        // Divide by zero and signed overflow
        run_op(3'b100, 32'd5, 32'd0, 0);
        run_op(3'b100, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(3'b111, 32'd5, 32'd0, 0);
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(3'b100, MIN_INT, 32'hFFFF_FFFF, 0);
        run_op(3'b110, MIN_INT, 32'hFFFF_FFFF, 0);
        // Back-to-back: next start is asserted in the done cycle
        run_op(3'b101, 32'hDEAD_BEEF, 32'd13, 0);
        run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // done is a single-cycle pulse
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);

        // Flush mid-DIV, with start requested alongside flush
        begin
            logic [31:0] prev;
            prev = result;
            op = 3'b100; a = 32'd1000; b = 32'd9; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (10) @(negedge clk);
            flush = 1'b1; start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
            @(negedge clk);
            check("flush_busy_falls", 32'(busy), 32'd0);
            @(negedge clk);
            flush = 1'b0; start = 1'b0;
            watch_idle(40, prev, "flush");
        end
        run_op(3'b000, 32'd3, 32'd4, 0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        op = 3'b101; a = 32'd12345; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        watch_idle(40, 32'd0, "post_reset");

        // Random operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), (i % 4 == 0) ? 6 : 0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
